// File: rtl/vga_timing_generator.sv
// VGA raster timing generator: programmable porches, sync widths and polarities,
// registered coordinates, display enable and line/frame start strobes.
module vga_timing_generator #(
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned H_FRONT      = 24,
    parameter int unsigned H_SYNC       = 136,
    parameter int unsigned H_BACK       = 184,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned V_FRONT      = 3,
    parameter int unsigned V_SYNC       = 6,
    parameter int unsigned V_BACK       = 29,
    parameter bit          HSYNC_POL    = 1'b0,
    parameter bit          VSYNC_POL    = 1'b0,
    parameter int unsigned COUNTER_SIZE = 11
) (
    input  logic                    control_clock,
    input  logic                    reset_n,
    input  logic                    pixel_enable,
    output logic [COUNTER_SIZE-1:0] h_count,
    output logic [COUNTER_SIZE-1:0] v_count,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    display_enable,
    output logic                    line_start,
    output logic                    frame_start
);

    localparam int unsigned CW      = COUNTER_SIZE;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_DE_END   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_DE_END   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);

    // Reject geometries the counters cannot represent or with empty porch/sync regions
    if ((H_TOTAL > (2 ** CW)) || (V_TOTAL > (2 ** CW)) ||
        (H_FRONT < 1) || (H_SYNC < 1) || (H_BACK < 1) ||
        (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_param_err
        $error("vga_timing_generator: invalid timing parameters for COUNTER_SIZE");
    end

    logic [CW-1:0] r_h_count;
    logic [CW-1:0] r_v_count;
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_display_enable;
    logic          r_line_start;
    logic          r_frame_start;

    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_in_sync;
    logic          w_v_in_sync;
    logic          w_de_next;

    // Next raster position and its decode, so registered flags match registered counters
    always_comb begin
        w_h_wrap    = (r_h_count == H_LAST);
        w_v_wrap    = (r_v_count == V_LAST);
        w_h_next    = w_h_wrap ? '0 : r_h_count + CW'(1);
        w_v_next    = r_v_count;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v_count + CW'(1);
        end
        w_h_in_sync = (w_h_next >= H_SYNC_BEG) && (w_h_next < H_SYNC_END);
        w_v_in_sync = (w_v_next >= V_SYNC_BEG) && (w_v_next < V_SYNC_END);
        w_de_next   = (w_h_next < H_DE_END) && (w_v_next < V_DE_END);
    end

    always_ff @(posedge control_clock) begin
        if (!reset_n) begin
            r_h_count        <= H_LAST;
            r_v_count        <= V_LAST;
            r_h_sync         <= ~HSYNC_POL;
            r_v_sync         <= ~VSYNC_POL;
            r_display_enable <= 1'b0;
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end else if (pixel_enable) begin
            r_h_count        <= w_h_next;
            r_v_count        <= w_v_next;
            r_h_sync         <= w_h_in_sync ? HSYNC_POL : ~HSYNC_POL;
            r_v_sync         <= w_v_in_sync ? VSYNC_POL : ~VSYNC_POL;
            r_display_enable <= w_de_next;
            r_line_start     <= (w_h_next == '0);
            r_frame_start    <= (w_h_next == '0) && (w_v_next == '0);
        end else begin
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end
    end

    assign h_count        = r_h_count;
    assign v_count        = r_v_count;
    assign h_sync         = r_h_sync;
    assign v_sync         = r_v_sync;
    assign display_enable = r_display_enable;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: four geometries driven in lockstep, checked
// against a position-index raster model and period/count measurements.
module tb_vga_timing_generator;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
    } obs_t;
    typedef obs_t [3:0] obs4_t;

    // 0: small, 1: small with positive syncs, 2: default, 3: small lines, default frame
    localparam int P_HA [4] = '{8, 8, 1024, 8};
    localparam int P_HF [4] = '{2, 2, 24, 2};
    localparam int P_HS [4] = '{3, 3, 136, 3};
    localparam int P_HB [4] = '{3, 3, 184, 3};
    localparam int P_VA [4] = '{4, 4, 768, 768};
    localparam int P_VF [4] = '{1, 1, 3, 3};
    localparam int P_VS [4] = '{2, 2, 6, 6};
    localparam int P_VB [4] = '{1, 1, 29, 29};
    localparam bit P_HP [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit P_VP [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    logic [4:0]  s_h, s_v, p_h, p_v;
    logic [10:0] d_h, d_v, v_h, v_v;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic p_hs, p_vs, p_de, p_ls, p_fs;
    logic d_hs, d_vs, d_de, d_ls, d_fs;
    logic v_hs, v_vs, v_de, v_ls, v_fs;

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COUNTER_SIZE(5)
    ) dut_s (
        .control_clock(clk), .reset_n(rst_n), .pixel_enable(en),
        .h_count(s_h), .v_count(s_v), .h_sync(s_hs), .v_sync(s_vs),
        .display_enable(s_de), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COUNTER_SIZE(5)
    ) dut_p (
        .control_clock(clk), .reset_n(rst_n), .pixel_enable(en),
        .h_count(p_h), .v_count(p_v), .h_sync(p_hs), .v_sync(p_vs),
        .display_enable(p_de), .line_start(p_ls), .frame_start(p_fs)
    );

    vga_timing_generator dut_d (
        .control_clock(clk), .reset_n(rst_n), .pixel_enable(en),
        .h_count(d_h), .v_count(d_v), .h_sync(d_hs), .v_sync(d_vs),
        .display_enable(d_de), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(768), .V_FRONT(3), .V_SYNC(6), .V_BACK(29),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COUNTER_SIZE(11)
    ) dut_v (
        .control_clock(clk), .reset_n(rst_n), .pixel_enable(en),
        .h_count(v_h), .v_count(v_v), .h_sync(v_hs), .v_sync(v_vs),
        .display_enable(v_de), .line_start(v_ls), .frame_start(v_fs)
    );

    obs_t obs [4];
    assign obs[0] = {11'(s_h), 11'(s_v), s_hs, s_vs, s_de, s_ls, s_fs};
    assign obs[1] = {11'(p_h), 11'(p_v), p_hs, p_vs, p_de, p_ls, p_fs};
    assign obs[2] = {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs};
    assign obs[3] = {v_h, v_v, v_hs, v_vs, v_de, v_ls, v_fs};

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    pos [4];
    obs4_t exp_q [$];
    int    en_l [4], hs_l [4], en_f [4], de_f [4], vs_f [4], frames [4], lines [4];
    bit    ls_ok [4], fs_ok [4];
    bit    in_c = 1'b0;
    int    c_fs_first = -1;
    int    c_fs_period = -1;

    function automatic int total_h(int id);
        return P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id];
    endfunction

    function automatic int total_v(int id);
        return P_VA[id] + P_VF[id] + P_VS[id] + P_VB[id];
    endfunction

    // Raster position p counts enabled pixels since the frame origin
    function automatic obs_t model(int id, int p, bit adv);
        obs_t o;
        int   h;
        int   v;
        h    = p % total_h(id);
        v    = p / total_h(id);
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.hs = (h >= P_HA[id] + P_HF[id] && h < P_HA[id] + P_HF[id] + P_HS[id]) ? P_HP[id] : !P_HP[id];
        o.vs = (v >= P_VA[id] + P_VF[id] && v < P_VA[id] + P_VF[id] + P_VS[id]) ? P_VP[id] : !P_VP[id];
        o.de = (h < P_HA[id]) && (v < P_VA[id]);
        o.ls = adv && (h == 0);
        o.fs = adv && (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic chk(input string tag, input int id, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s inst%0d cyc%0d observed=%0d expected=%0d", tag, id, cyc, got, expv);
        end
    endtask

    task automatic measure(input int i, input bit rst, input bit adv);
        if (rst) begin
            ls_ok[i] = 1'b0;
            fs_ok[i] = 1'b0;
        end else if (adv) begin
            if (obs[i].ls === 1'b1) begin
                if (ls_ok[i]) begin
                    chk("line_period", i, en_l[i], total_h(i));
                    chk("hsync_per_line", i, hs_l[i], P_HS[i]);
                    lines[i]++;
                end
                ls_ok[i] = 1'b1;
                en_l[i]  = 0;
                hs_l[i]  = 0;
            end
            if (obs[i].fs === 1'b1) begin
                if (fs_ok[i]) begin
                    chk("frame_period", i, en_f[i], total_h(i) * total_v(i));
                    chk("de_per_frame", i, de_f[i], P_HA[i] * P_VA[i]);
                    chk("vsync_per_frame", i, vs_f[i], P_VS[i] * total_h(i));
                    frames[i]++;
                end
                fs_ok[i] = 1'b1;
                en_f[i]  = 0;
                de_f[i]  = 0;
                vs_f[i]  = 0;
            end
            en_l[i]++;
            en_f[i]++;
            hs_l[i] += int'(obs[i].hs === P_HP[i]);
            de_f[i] += int'(obs[i].de === 1'b1);
            vs_f[i] += int'(obs[i].vs === P_VP[i]);
        end
    endtask

    // One clock: drive, push expectation, then compare after the edge
    task automatic step(input bit rst, input bit adv);
        obs4_t e;
        obs4_t g;
        @(negedge clk);
        rst_n = !rst;
        en    = adv;
        for (int i = 0; i < 4; i++) begin
            if (rst) pos[i] = total_h(i) * total_v(i) - 1;
            else if (adv) pos[i] = (pos[i] + 1) % (total_h(i) * total_v(i));
            e[i] = model(i, pos[i], !rst && adv);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        g = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk("h_count", i, obs[i].h, g[i].h);
            chk("v_count", i, obs[i].v, g[i].v);
            chk("h_sync", i, obs[i].hs, g[i].hs);
            chk("v_sync", i, obs[i].vs, g[i].vs);
            chk("display_enable", i, obs[i].de, g[i].de);
            chk("line_start", i, obs[i].ls, g[i].ls);
            chk("frame_start", i, obs[i].fs, g[i].fs);
            measure(i, rst, adv);
        end
        if (in_c && obs[0].fs === 1'b1) begin
            if (c_fs_first < 0) c_fs_first = cyc;
            else if (c_fs_period < 0) c_fs_period = cyc - c_fs_first;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pos[i] = 0; en_l[i] = 0; hs_l[i] = 0; en_f[i] = 0; de_f[i] = 0;
            vs_f[i] = 0; frames[i] = 0; lines[i] = 0; ls_ok[i] = 1'b0; fs_ok[i] = 1'b0;
        end

        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("reset_h", 0, obs[0].h, 15);
        chk("reset_v", 0, obs[0].v, 7);
        chk("reset_hsync_pos_pol", 1, obs[1].hs, 0);
        chk("reset_vsync_pos_pol", 1, obs[1].vs, 0);
        chk("reset_de", 2, obs[2].de, 0);

        step(1'b0, 1'b1);
        chk("first_h", 0, obs[0].h, 0);
        chk("first_fs", 0, obs[0].fs, 1);
        chk("first_de", 0, obs[0].de, 1);
        chk("first_fs_default", 2, obs[2].fs, 1);

        repeat (1500) step(1'b0, 1'b1);

        in_c = 1'b1;
        repeat (300) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        in_c = 1'b0;
        chk("toggle_frame_clocks", 0, c_fs_period, 256);

        n = 0;
        while (pos[0] != 5 * 16 + 9 && n < 300) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("pre_reset_h", 0, obs[0].h, 9);
        chk("pre_reset_v", 0, obs[0].v, 5);
        step(1'b1, 1'b1);
        chk("midreset_h", 0, obs[0].h, 15);
        chk("midreset_v", 0, obs[0].v, 7);
        chk("midreset_fs", 0, obs[0].fs, 0);
        step(1'b0, 1'b1);
        chk("post_reset_h", 0, obs[0].h, 0);
        chk("post_reset_v", 0, obs[0].v, 0);
        chk("post_reset_fs", 0, obs[0].fs, 1);

        repeat (13000) step(1'b0, 1'b1);
        chk("default_line_measured", 2, int'(lines[2] > 0), 1);
        chk("vframe_measured", 3, int'(frames[3] > 0), 1);
        chk("small_frames_measured", 0, int'(frames[0] > 10), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised VGA raster timing generator: the next generation of the team's VGA controller. It produces horizontal and vertical sync with programmable porches, sync widths and polarities, plus registered pixel coordinates, a display-enable, and line/frame start strobes. A pixel-clock enable lets it run from a fast system clock. It sits between the clock source and the pixel pipeline / framebuffer reader.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch (pixels, ≥1)
- H_SYNC, 136, horizontal sync width (pixels, ≥1)
- H_BACK, 184, horizontal back porch (pixels, ≥1); H_TOTAL = sum = 1368
- V_ACTIVE, 768, visible lines per frame
- V_FRONT, 3, vertical front porch (lines, ≥1)
- V_SYNC, 6, vertical sync width (lines, ≥1)
- V_BACK, 29, vertical back porch (lines, ≥1); V_TOTAL = sum = 806
- HSYNC_POL, 0, asserted level of h_sync (0 = active-low)
- VSYNC_POL, 0, asserted level of v_sync
- COUNTER_SIZE, 11, width of both counters; H_TOTAL and V_TOTAL must be ≤ 2^COUNTER_SIZE (elaboration error otherwise)

Ports:
- control_clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- pixel_enable  in  1  advance one pixel position this cycle; tie high for 1 pixel/clock
- h_count  out  COUNTER_SIZE  current pixel column, 0..H_TOTAL-1
- v_count  out  COUNTER_SIZE  current line, 0..V_TOTAL-1
- h_sync  out  1  horizontal sync, polarity per HSYNC_POL
- v_sync  out  1  vertical sync, polarity per VSYNC_POL
- display_enable  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE
- line_start  out  1  one-clock strobe: h_count just became 0
- frame_start  out  1  one-clock strobe: (h_count, v_count) just became (0, 0)

## Operation
- Horizontal counter: on a cycle with pixel_enable=1, h_count increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on an enabled cycle where h_count wraps; at V_TOTAL-1 it wraps to 0.
- Horizontal regions, by h_count: active [0, H_ACTIVE); front porch [H_ACTIVE, H_ACTIVE+H_FRONT); sync [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC); back porch up to H_TOTAL-1. Vertical regions are identical using the V_ parameters and v_count.
- h_sync equals HSYNC_POL while h_count is in the sync region, otherwise ~HSYNC_POL. v_sync works the same way on v_count. Sync does not depend on the other axis.
- All outputs are registered. They are decoded from next-state counter values, so in every cycle the sync, display_enable and strobes are consistent with the h_count/v_count presented in that cycle.
- pixel_enable=0: counters, syncs and display_enable hold. line_start and frame_start are 0.
- Comparisons use COUNTER_SIZE-bit unsigned arithmetic. Region boundaries are elaboration-time constants.

## Timing
- Reset (reset_n=0 at a clock edge): h_count=H_TOTAL-1, v_count=V_TOTAL-1, h_sync=~HSYNC_POL, v_sync=~VSYNC_POL, display_enable=0, line_start=0, frame_start=0.
- Reset takes effect mid-frame on the next edge. Nothing partial survives.
- First enabled cycle after reset release: counters go to (0,0), and display_enable, line_start and frame_start are all 1.
- Latency from pixel_enable to output change: one clock.
- Per-pixel behaviour: one position per enabled cycle. No position is skipped or repeated regardless of the pixel_enable pattern.
- Frame period is H_TOTAL × V_TOTAL enabled cycles. The line_start period is H_TOTAL enabled cycles.
- frame_start implies line_start in the same cycle.

## Test plan
- Small config (H 8/2/3/3, V 4/1/2/1, COUNTER_SIZE 5), pixel_enable=1, reset released:
  - first cycle gives (0,0) with frame_start=1
  - h_sync is low exactly at h_count 10..12
  - display_enable is high for h_count 0..7 on v_count 0..3
  - frame_start repeats every 128 cycles
- Same config with pixel_enable toggling 1,0,1,0: counters advance only on enabled cycles, strobes never last longer than one clock, and the frame period is 256 clocks.
- HSYNC_POL=1, VSYNC_POL=1: sync is high only in the sync regions, v_sync is high for v_count 5..6, and the reset level is 0.
- Assert reset_n=0 at (h=9, v=5) for one cycle: the next cycle shows the reset values, and the following enabled cycle shows (0,0) with frame_start=1.
- Default 1024×768 parameters:
  - H_TOTAL=1368 and V_TOTAL=806 are measured
  - h_sync is low for h_count 1048..1183
  - v_sync is low for v_count 771..776
  - the display_enable count per frame is 786432
- Wrap corner: at (H_TOTAL-1, V_TOTAL-1) with pixel_enable=1, the next cycle is (0,0) with line_start=1, frame_start=1 and v_sync inactive.
